// File: rtl/rgb_byte_to_gray_if.sv
// ---------------------------------------------------------------------------
// rgb_byte_to_gray_if
// Bundles the byte-stream input and the tagged gray-pixel output of
// rgb_byte_to_gray. Clock and reset stay plain ports on the module.
//
//   data_valid / data_in  : serial R,G,B byte stream (source -> converter)
//   gray_valid            : one-cycle strobe for a completed pixel
//   gray_out              : 8-bit luminance
//   x / y                 : pixel coordinates (XW / YW bits)
//   sof / eol / eof       : start-of-frame, end-of-line, end-of-frame markers
//   frame_cnt             : completed frames, wraps 255 -> 0
//
// master : the side that drives bytes and consumes pixels
// slave  : the converter itself
// ---------------------------------------------------------------------------
interface rgb_byte_to_gray_if #(
    parameter int XW = 9,
    parameter int YW = 9
);
    logic          data_valid;
    logic [7:0]    data_in;
    logic          gray_valid;
    logic [7:0]    gray_out;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          sof;
    logic          eol;
    logic          eof;
    logic [7:0]    frame_cnt;

    modport master (
        output data_valid, data_in,
        input  gray_valid, gray_out, x, y, sof, eol, eof, frame_cnt
    );

    modport slave (
        input  data_valid, data_in,
        output gray_valid, gray_out, x, y, sof, eol, eof, frame_cnt
    );
endinterface

// File: rtl/rgb_byte_to_gray.sv
// ---------------------------------------------------------------------------
// rgb_byte_to_gray
// Regroups a serial R,G,B byte stream into pixels, converts each pixel to
// 8-bit luminance gray = (KR*R + KG*G + KB*B) >> 8, and tags it with x/y
// coordinates, frame/line markers and a running frame counter.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : rgb_byte_to_gray_if.slave (byte stream in, gray pixel out)
//
// Timing: the pixel is registered on the edge that accepts its B byte, so
// gray_valid pulses one cycle after B is presented. Any cycle without
// data_valid resynchronises the byte phase and the x/y counters to the
// start of a frame; frame_cnt is kept across such gaps.
// ---------------------------------------------------------------------------
module rgb_byte_to_gray #(
    parameter int W  = 450,
    parameter int H  = 450,
    parameter int XW = 9,
    parameter int YW = 9,
    parameter int KR = 77,
    parameter int KG = 150,
    parameter int KB = 29
) (
    input  logic                clk,
    input  logic                rst_n,
    rgb_byte_to_gray_if.slave   bus
);

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    phase_t        phase_q;
    logic [7:0]    r_q;
    logic [7:0]    g_q;
    logic [XW-1:0] col_q;
    logic [YW-1:0] row_q;

    logic          gray_valid_q;
    logic [7:0]    gray_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          sof_q;
    logic          eol_q;
    logic          eof_q;
    logic [7:0]    frame_cnt_q;

    // Weighted sum; B comes straight from the bus in the accepting cycle.
    // Weights sum to 256, so the top byte never exceeds 255.
    logic [15:0]   sum_d;
    logic [7:0]    gray_d;
    logic          last_col_d;
    logic          last_row_d;

    always_comb begin
        sum_d      = 16'(KR) * {8'd0, r_q}
                   + 16'(KG) * {8'd0, g_q}
                   + 16'(KB) * {8'd0, bus.data_in};
        gray_d     = sum_d[15:8];
        last_col_d = (col_q == XW'(W - 1));
        last_row_d = (row_q == YW'(H - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_R;
            r_q          <= '0;
            g_q          <= '0;
            col_q        <= '0;
            row_q        <= '0;
            gray_valid_q <= 1'b0;
            gray_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            sof_q        <= 1'b0;
            eol_q        <= 1'b0;
            eof_q        <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            gray_valid_q <= 1'b0;
            if (!bus.data_valid) begin
                // Source restarts at byte 0 after a gap: drop any partial
                // pixel and restart coordinates. data_in is not sampled here.
                phase_q <= PH_R;
                col_q   <= '0;
                row_q   <= '0;
            end else begin
                case (phase_q)
                    PH_R: begin
                        r_q     <= bus.data_in;
                        phase_q <= PH_G;
                    end
                    PH_G: begin
                        g_q     <= bus.data_in;
                        phase_q <= PH_B;
                    end
                    PH_B: begin
                        gray_valid_q <= 1'b1;
                        gray_q       <= gray_d;
                        x_q          <= col_q;
                        y_q          <= row_q;
                        sof_q        <= (col_q == '0) && (row_q == '0);
                        eol_q        <= last_col_d;
                        eof_q        <= last_col_d && last_row_d;
                        phase_q      <= PH_R;
                        if (last_col_d) begin
                            col_q <= '0;
                            if (last_row_d) begin
                                row_q       <= '0;
                                frame_cnt_q <= frame_cnt_q + 8'd1;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                    default: phase_q <= PH_R;
                endcase
            end
        end
    end

    assign bus.gray_valid = gray_valid_q;
    assign bus.gray_out   = gray_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.sof        = sof_q;
    assign bus.eol        = eol_q;
    assign bus.eof        = eof_q;
    assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_rgb_byte_to_gray.sv
// ---------------------------------------------------------------------------
// tb_rgb_byte_to_gray
// Drives directed byte vectors into a 4x2-pixel instance. A pixel-index
// model (bytes -> pixels -> position = index mod W*H) predicts every output
// each cycle; literal expectations pin the model on known pixels.
// ---------------------------------------------------------------------------
module tb_rgb_byte_to_gray;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int XW = 2;
    localparam int YW = 1;

    logic clk;
    logic rst_n;

    rgb_byte_to_gray_if #(.XW(XW), .YW(YW)) bus ();

    rgb_byte_to_gray #(
        .W(W), .H(H), .XW(XW), .YW(YW), .KR(77), .KG(150), .KB(29)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model state
    int         nbytes;
    logic [7:0] rb, gb;
    int         pix_idx;
    int         frames;
    logic       exp_valid;
    logic [7:0] exp_gray;
    int         exp_x, exp_y;
    logic       exp_sof, exp_eol, exp_eof;

    int strobe_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_reset();
        nbytes = 0; pix_idx = 0; frames = 0; rb = 0; gb = 0;
        exp_valid = 0; exp_gray = 0; exp_x = 0; exp_y = 0;
        exp_sof = 0; exp_eol = 0; exp_eof = 0;
    endtask

    // One clock: drive inputs, advance model, then compare every output.
    task automatic cycle(input bit v, input logic [7:0] d);
        @(negedge clk);
        bus.data_valid = v;
        bus.data_in    = v ? d : 8'hzz;
        exp_valid = 1'b0;
        if (!v) begin
            nbytes  = 0;
            pix_idx = 0;
        end else if (nbytes == 0) begin
            rb = d; nbytes = 1;
        end else if (nbytes == 1) begin
            gb = d; nbytes = 2;
        end else begin
            exp_gray  = 8'((77 * int'(rb) + 150 * int'(gb) + 29 * int'(d)) / 256);
            exp_x     = pix_idx % W;
            exp_y     = pix_idx / W;
            exp_sof   = (pix_idx == 0);
            exp_eol   = (exp_x == W - 1);
            exp_eof   = (pix_idx == W * H - 1);
            if (exp_eof) frames = (frames + 1) % 256;
            pix_idx   = (pix_idx + 1) % (W * H);
            nbytes    = 0;
            exp_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (bus.gray_valid === 1'b1) strobe_cyc.push_back(cyc);
        chk("gray_valid", 32'(bus.gray_valid), 32'(exp_valid));
        chk("gray_out",   32'(bus.gray_out),   32'(exp_gray));
        chk("x",          32'(bus.x),          32'(exp_x));
        chk("y",          32'(bus.y),          32'(exp_y));
        chk("sof",        32'(bus.sof),        32'(exp_sof));
        chk("eol",        32'(bus.eol),        32'(exp_eol));
        chk("eof",        32'(bus.eof),        32'(exp_eof));
        chk("frame_cnt",  32'(bus.frame_cnt),  32'(frames));
        if (exp_valid)
            $display("[TB] cyc %0d pixel (%0d,%0d) gray=%0d sof=%0b eol=%0b eof=%0b frames=%0d",
                     cyc, bus.x, bus.y, bus.gray_out, bus.sof, bus.eol, bus.eof, bus.frame_cnt);
    endtask

    task automatic send_px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        cycle(1'b1, r);
        cycle(1'b1, g);
        cycle(1'b1, b);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gv"},  32'(bus.gray_valid), 32'd0);
        chk({tag, "_gray"},32'(bus.gray_out),   32'd0);
        chk({tag, "_x"},   32'(bus.x),          32'd0);
        chk({tag, "_y"},   32'(bus.y),          32'd0);
        chk({tag, "_sof"}, 32'(bus.sof),        32'd0);
        chk({tag, "_eol"}, 32'(bus.eol),        32'd0);
        chk({tag, "_eof"}, 32'(bus.eof),        32'd0);
        chk({tag, "_fc"},  32'(bus.frame_cnt),  32'd0);
    endtask

    logic [7:0] vec_r [4] = '{8'd255, 8'd0,   8'd0,   8'd100};
    logic [7:0] vec_g [4] = '{8'd255, 8'd255, 8'd0,   8'd150};
    logic [7:0] vec_b [4] = '{8'd255, 8'd0,   8'd255, 8'd200};
    logic [7:0] vec_y [4] = '{8'd255, 8'd149, 8'd28,  8'd140};

    initial begin
        rst_n          = 1'b0;
        bus.data_valid = 1'b0;
        bus.data_in    = 8'h00;
        model_reset();
        #12;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single red pixel
        send_px(8'd255, 8'd0, 8'd0);
        chk("red_gray", 32'(bus.gray_out), 32'd76);
        chk("red_sof",  32'(bus.sof),      32'd1);
        chk("red_x",    32'(bus.x),        32'd0);

        // Four known pixels back-to-back from a fresh line
        cycle(1'b0, 8'h00);
        strobe_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            send_px(vec_r[i], vec_g[i], vec_b[i]);
            chk("vec_gray", 32'(bus.gray_out), 32'(vec_y[i]));
            chk("vec_x",    32'(bus.x),        32'(i));
            chk("vec_eol",  32'(bus.eol),      32'(i == 3));
        end
        chk("vec_strobes", 32'(strobe_cyc.size()), 32'd4);
        for (int i = 1; i < strobe_cyc.size(); i++)
            chk("vec_spacing", 32'(strobe_cyc[i] - strobe_cyc[i-1]), 32'd3);

        // Two full frames continuous
        cycle(1'b0, 8'h00);
        strobe_cyc.delete();
        for (int p = 0; p < 16; p++) begin
            send_px(8'(p * 13), 8'(p * 7 + 5), 8'(255 - p * 11));
            chk("frm_eof", 32'(bus.eof), 32'((p == 7) || (p == 15)));
            chk("frm_y",   32'(bus.y),   32'((p % 8) / 4));
        end
        chk("frm_strobes", 32'(strobe_cyc.size()), 32'd16);
        chk("frm_cnt2",    32'(bus.frame_cnt),     32'd2);

        // Gap after R,G of pixel (2,1) discards it
        for (int p = 0; p < 6; p++) send_px(8'(p + 40), 8'(p + 80), 8'(p + 120));
        cycle(1'b1, 8'd200);
        cycle(1'b1, 8'd201);
        cycle(1'b0, 8'h00);
        send_px(8'd10, 8'd20, 8'd30);
        chk("gap_gray", 32'(bus.gray_out), 32'd18);
        chk("gap_sof",  32'(bus.sof),      32'd1);
        chk("gap_x",    32'(bus.x),        32'd0);
        chk("gap_y",    32'(bus.y),        32'd0);
        chk("gap_fc",   32'(bus.frame_cnt),32'd2);

        // Asynchronous reset mid-pixel, between edges
        send_px(8'd1, 8'd2, 8'd3);
        cycle(1'b1, 8'd50);
        #2;
        rst_n          = 1'b0;
        bus.data_valid = 1'b0;
        #1;
        chk_all_zero("arst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_px(8'd0, 8'd0, 8'd255);
        chk("arst_gray", 32'(bus.gray_out), 32'd28);
        chk("arst_x",    32'(bus.x),        32'd0);
        chk("arst_sof",  32'(bus.sof),      32'd1);
        chk("arst_fc",   32'(bus.frame_cnt),32'd0);

        // Long idle with floating data
        for (int i = 0; i < 20; i++) cycle(1'b0, 8'h00);
        chk("idle_hold", 32'(bus.gray_out), 32'd28);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
